ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive locked transfers per requester (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  requester n requests a RAM access this cycle.
REQ-005 lock0 / lock1  input  1  requester n asks to keep ownership after this transfer.
REQ-006 we0 / we1  input  1  1 = write, 0 = read.
REQ-007 addr0 / addr1  input  4  word address, 16 locations.
REQ-008 wdata0 / wdata1  input  8  write data.
REQ-009 gnt0 / gnt1  output  1  combinational grant; a transfer is accepted when reqn & gntn is high at a rising edge.
REQ-010 rvalid0 / rvalid1  output  1  registered one-cycle pulse: read data for requester n is valid.
REQ-011 rdata0 / rdata1  output  8  registered read data, held until the next read completes for that requester.

Function
REQ-012 The block SHALL own one 16x8 RAM with synchronous write and a registered read of 1-cycle latency, with at most one access per cycle.
REQ-013 gnt0 and gnt1 SHALL never both be high.
REQ-014 In state ARB: one requester active -> grant it; both active -> grant the requester that is not last_served; neither -> no grant, RAM wr_en=0, addr=0.
REQ-015 last_served SHALL update to n on every accepted transfer from n.
REQ-016 The granted requester's we/addr/wdata SHALL drive the RAM in the same cycle; a write commits at that edge.
REQ-017 An accepted read at edge N SHALL produce rvalidn=1 and rdatan=mem[addr] in the cycle after edge N+1 (latency 2 edges, counted from the accepted edge).
REQ-018 rvalidn SHALL be 0 in every cycle without a completing read; rdatan SHALL hold its last value.
REQ-019 States ARB, LOCK0, LOCK1. From ARB, an accepted transfer from n with lockn=1 -> LOCKn, burst count = 1.
REQ-020 In LOCKn only requester n SHALL be granted, and only when reqn=1; the other requester SHALL wait regardless of priority.
REQ-021 In LOCKn each accepted transfer SHALL increment the burst count.
REQ-022 LOCKn -> ARB when any of the following holds: an accepted transfer has lockn=0; an accepted transfer brings the count to MAX_BURST; reqn=0 for a cycle (idle release).
REQ-023 On leaving LOCKn, last_served SHALL be n, so that the other requester wins the next contention.
REQ-024 MAX_BURST=1 SHALL make lock ineffective: the state SHALL return to ARB after the single transfer.
REQ-025 Back-to-back accepted reads from alternating requesters SHALL each be routed to the issuing requester's rvalid/rdata, with no loss.

Reset
REQ-026 While rst=1: state=ARB, last_served=1 (requester 0 has first priority), burst count=0, rvalid0=rvalid1=0, rdata0=rdata1=8'h00, and all 16 RAM words cleared to 0.
REQ-027 gnt0 and gnt1 SHALL be 0 while rst=1.
REQ-028 A read in flight when rst asserts SHALL be dropped, with no rvalid after reset.
REQ-029 Reset asserted during LOCKn SHALL abandon the burst.

Structure
REQ-030 A shared package SHALL hold the state enumeration (ARB, LOCK0, LOCK1), the address width 4, the data width 8 and the depth 16.
REQ-031 The RAM SHALL be one sub-module, ram_16x8 (clk, rst, wr_en, addr, data_in, data_out), instantiated once; the arbiter, burst counter and read-response routing SHALL live in ram_arbiter.
REQ-032 The read-response tag SHALL be a 1-bit valid plus a 1-bit requester id, pipelined alongside the RAM read.

Verification
REQ-033 Reset, then requester 0 reads addr 5 -> rvalid0 pulses once with rdata0=8'h00.
REQ-034 Requester 0 writes 8'hA5 to addr 3, then requester 1 reads addr 3 -> rdata1=8'hA5; rvalid0 stays 0.
REQ-035 Both requesters hold reads (no lock) for 6 cycles -> grants alternate 0,1,0,1,0,1 and each rvalid pulses 3 times with correct data.
REQ-036 MAX_BURST=4; requester 1 holds lock1=1 and req1=1 while requester 0 holds req0=1 -> exactly 4 consecutive gnt1, then gnt0.
REQ-037 Requester 0 locks and then drops req0 for 1 cycle -> next cycle ARB and gnt1 if req1=1.
REQ-038 rst pulsed during LOCK0 with a read in flight -> no rvalid0, memory all zero, requester 0 priority afterward.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and sizes for the two-port RAM arbiter
package ram_arbiter_pkg;
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
endpackage

// File: rtl/ram_16x8.sv
// rtl/ram_16x8.sv - 16x8 RAM, synchronous write, registered read, clears on reset
module ram_16x8
  import ram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents when a write hits the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_out <= '0;
    end else begin
      if (wr_en) mem[addr] <= data_in;
      data_out <= mem[addr];
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester RAM arbiter with lock bursts and tagged read returns
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);
  localparam logic [3:0] MAX_B   = 4'(MAX_BURST);
  localparam bit         LOCK_OK = (MAX_BURST > 1);

  state_t            state;
  logic              last_served;
  logic [3:0]        burst_cnt;
  logic [3:0]        cnt_next;
  logic              wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_dout;
  logic              tag_valid;
  logic              tag_id;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (req0 && (!req1 || last_served)) gnt0 = 1'b1;
          else if (req1)                      gnt1 = 1'b1;
        end
        LOCK0:   gnt0 = req0;
        LOCK1:   gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      wr_en = we0; ram_addr = addr0; ram_wdata = wdata0;
    end else if (gnt1) begin
      wr_en = we1; ram_addr = addr1; ram_wdata = wdata1;
    end
  end

  assign cnt_next = burst_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      last_served <= 1'b1;
      burst_cnt   <= '0;
    end else begin
      case (state)
        ARB: begin
          if (gnt0) begin
            last_served <= 1'b0;
            if (lock0 && LOCK_OK) begin state <= LOCK0; burst_cnt <= 4'd1; end
          end else if (gnt1) begin
            last_served <= 1'b1;
            if (lock1 && LOCK_OK) begin state <= LOCK1; burst_cnt <= 4'd1; end
          end
        end
        LOCK0: begin
          // Any exit (lock dropped, burst limit, idle) leaves last_served at 0.
          last_served <= 1'b0;
          if (gnt0 && lock0 && cnt_next != MAX_B) burst_cnt <= cnt_next;
          else begin state <= ARB; burst_cnt <= '0; end
        end
        LOCK1: begin
          last_served <= 1'b1;
          if (gnt1 && lock1 && cnt_next != MAX_B) burst_cnt <= cnt_next;
          else begin state <= ARB; burst_cnt <= '0; end
        end
        default: begin state <= ARB; burst_cnt <= '0; end
      endcase
    end
  end

  // Tag travels one stage alongside the RAM's registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      tag_valid <= (gnt0 | gnt1) & ~wr_en;
      tag_id    <= gnt1;
      rvalid0   <= tag_valid & ~tag_id;
      rvalid1   <= tag_valid & tag_id;
      if (tag_valid && !tag_id) rdata0 <= ram_dout;
      if (tag_valid &&  tag_id) rdata1 <= ram_dout;
    end
  end

  ram_16x8 u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .addr     (ram_addr),
    .data_in  (ram_wdata),
    .data_out (ram_dout)
  );
endmodule
